uart_rx_ctrl: RTL and testbench

Controller that sequences the UART receiver in the uart_transport datapath. It generates the receiver's oversample clock enable from a programmable divider and runs the receiver's rdy/rdy_clr handshake. It buffers received bytes in a small FIFO with a valid/ready output stream, tracks overruns, and optionally flags end-of-frame on line idle.

---
 rtl/uart_rx_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Sequencing controller for the UART receiver in the uart_transport datapath.
//   * Baud generator: programmable divider producing the receiver's oversample
//     clock enable (rx_clken period = div+1 clk cycles while en=1).
//   * Handshake FSM: captures rx_data on rx_rdy and returns a one-cycle
//     rx_rdy_clr pulse; each byte occupies the FSM for 3 cycles.
//   * FIFO: DEPTH-entry first-word-fall-through buffer with a valid/ready
//     output stream (m_data/m_valid/m_ready) and occupancy (level).
//   * Overrun: sticky overrun flag and saturating dropped-byte counter,
//     cleared by ovr_clr.
//   * Optional end-of-frame detection on line idle, built only when the macro
//     UART_RX_CTRL_IDLE_EN is defined; otherwise frame_end is tied low.
//
// Parameters
//   DEPTH       FIFO entries, power of two, >= 2
//   IDLE_TICKS  rx_clken ticks of silence after the last byte before frame_end
//
// Ports
//   clk         clock, all logic on posedge
//   rstn        asynchronous active-low reset
//   en          baud generator enable
//   div[15:0]   divider
//   rx_clken    oversample enable to the receiver (registered)
//   rx_rdy      receiver byte-ready
//   rx_data     receiver byte
//   rx_rdy_clr  one-cycle clear pulse to the receiver (registered)
//   m_data      head-of-FIFO byte
//   m_valid     FIFO not empty
//   m_ready     consumer accepts m_data
//   level       FIFO occupancy
//   overrun     sticky dropped-byte flag
//   ovr_cnt     dropped-byte count, saturating at 255
//   ovr_clr     clears overrun and ovr_cnt
//   frame_end   one-cycle pulse after line idle (UART_RX_CTRL_IDLE_EN only)
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IDLE_TICKS = 320
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic [15:0]              div,
    output logic                     rx_clken,
    input  logic                     rx_rdy,
    input  logic [7:0]               rx_data,
    output logic                     rx_rdy_clr,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic [7:0]               ovr_cnt,
    input  logic                     ovr_clr,
    output logic                     frame_end
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("uart_rx_ctrl: DEPTH must be a power of two and at least 2");
    end
    if (IDLE_TICKS < 1) begin : g_idle_chk
        $error("uart_rx_ctrl: IDLE_TICKS must be at least 1");
    end

    // -------------------------------------------------------------------------
    // Baud generator
    // -------------------------------------------------------------------------
    logic [15:0] r_div_cnt;
    logic        r_clken;

    // Compare is against the live div value; if the count is already past a
    // newly lowered div it simply runs on to 0xFFFF and wraps without a pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div_cnt <= '0;
            r_clken   <= 1'b0;
        end else if (!en) begin
            r_div_cnt <= '0;
            r_clken   <= 1'b0;
        end else if (r_div_cnt == div) begin
            r_div_cnt <= '0;
            r_clken   <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
            r_clken   <= 1'b0;
        end
    end

    assign rx_clken = r_clken;

    // -------------------------------------------------------------------------
    // Receiver handshake FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        H_IDLE,
        H_CLR,
        H_HOLD
    } hs_state_t;

    hs_state_t r_hs_state;
    logic      r_rdy_clr;
    logic      w_cap;

    // A byte is captured only from H_IDLE; the following two states cover the
    // cycles in which the receiver is still dropping rdy.
    assign w_cap = (r_hs_state == H_IDLE) && rx_rdy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hs_state <= H_IDLE;
            r_rdy_clr  <= 1'b0;
        end else begin
            unique case (r_hs_state)
                H_IDLE: begin
                    if (rx_rdy) begin
                        r_rdy_clr  <= 1'b1;
                        r_hs_state <= H_CLR;
                    end else begin
                        r_rdy_clr  <= 1'b0;
                    end
                end
                H_CLR: begin
                    r_rdy_clr  <= 1'b0;
                    r_hs_state <= H_HOLD;
                end
                H_HOLD: begin
                    r_rdy_clr  <= 1'b0;
                    r_hs_state <= H_IDLE;
                end
                default: begin
                    r_rdy_clr  <= 1'b0;
                    r_hs_state <= H_IDLE;
                end
            endcase
        end
    end

    assign rx_rdy_clr = r_rdy_clr;

    // -------------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // -------------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_pop  = (r_level != '0) && m_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = w_cap && ((r_level != LW'(DEPTH)) || w_pop);
    assign w_drop = w_cap && !w_push;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= rx_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign m_data  = r_mem[r_rd_ptr];
    assign m_valid = (r_level != '0);
    assign level   = r_level;

    // -------------------------------------------------------------------------
    // Overrun tracking
    // -------------------------------------------------------------------------
    logic       r_overrun;
    logic [7:0] r_ovr_cnt;

    // A clear coinciding with a drop leaves that drop recorded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (ovr_clr) begin
            r_overrun <= w_drop;
            r_ovr_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (r_ovr_cnt != '1) begin
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
            end
        end
    end

    assign overrun = r_overrun;
    assign ovr_cnt = r_ovr_cnt;

    // -------------------------------------------------------------------------
    // End-of-frame on line idle
    // -------------------------------------------------------------------------
`ifdef UART_RX_CTRL_IDLE_EN
    localparam int unsigned IW = $clog2(IDLE_TICKS + 1);

    logic [IW-1:0] r_idle_cnt;
    logic          r_armed;
    logic          r_frame_end;

    // Every captured byte (accepted or dropped) restarts the silence window.
    // The counter parks at IDLE_TICKS; armed ensures one pulse per burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idle_cnt  <= '0;
            r_armed     <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_frame_end <= 1'b0;
            if (w_cap) begin
                r_idle_cnt <= '0;
                r_armed    <= 1'b1;
            end else if (r_clken && (r_idle_cnt != IW'(IDLE_TICKS))) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
                if (r_armed && (r_idle_cnt == IW'(IDLE_TICKS - 1))) begin
                    r_frame_end <= 1'b1;
                    r_armed     <= 1'b0;
                end
            end
        end
    end

    assign frame_end = r_frame_end;
`else
    assign frame_end = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDLE  = 320;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div = '0;
    logic        rx_clken;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy_clr;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [2:0]  level;
    logic        overrun;
    logic [7:0]  ovr_cnt;
    logic        ovr_clr = 1'b0;
    logic        frame_end;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_TICKS(IDLE)) dut (
        .clk(clk), .rstn(rstn), .en(en), .div(div), .rx_clken(rx_clken),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_rdy_clr(rx_rdy_clr),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .overrun(overrun), .ovr_cnt(ovr_cnt), .ovr_clr(ovr_clr),
        .frame_end(frame_end)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (spec rules, per clock edge) ----------
    int         m_level = 0;      // FIFO occupancy
    bit         prev_rdy = 0;     // rdy seen at previous edge (new byte = rising)
    bit         e_clken = 0;
    bit         e_clr = 0;
    bit         e_ov = 0;
    int         e_oc = 0;
    bit         e_fe = 0;
    logic [15:0] m_cnt = '0;
    int         m_ticks = 0;
    bit         m_armed = 0;
    logic [7:0] exp_q[$];         // scoreboard: bytes expected on m_data
    int         fe_seen = 0;

    always @(posedge clk or negedge rstn) begin : model
        bit pop, cap, drop;
        if (!rstn) begin
            m_level = 0; prev_rdy = 0; e_clken = 0; e_clr = 0; e_ov = 0;
            e_oc = 0; e_fe = 0; m_cnt = '0; m_ticks = 0; m_armed = 0;
            exp_q.delete();
        end else begin
            pop  = (m_level > 0) && m_ready;
            cap  = rx_rdy && !prev_rdy;
            prev_rdy = rx_rdy;
            drop = 0;
            if (pop) m_level--;
            if (cap) begin
                if (m_level < DEPTH) begin
                    m_level++;
                    exp_q.push_back(rx_data);
                end else begin
                    drop = 1;
                end
            end
            if (ovr_clr) begin
                e_ov = drop;
                e_oc = drop ? 1 : 0;
            end else if (drop) begin
                e_ov = 1;
                if (e_oc < 255) e_oc++;
            end
            e_clr = cap;
`ifdef UART_RX_CTRL_IDLE_EN
            e_fe = 0;
            if (cap) begin
                m_ticks = 0;
                m_armed = 1;
            end else if (e_clken && m_ticks < IDLE) begin
                m_ticks++;
                if (m_ticks == IDLE && m_armed) begin
                    e_fe = 1;
                    m_armed = 0;
                end
            end
`endif
            if (!en) begin
                m_cnt = '0; e_clken = 0;
            end else if (m_cnt == div) begin
                m_cnt = '0; e_clken = 1;
            end else begin
                m_cnt = m_cnt + 16'd1; e_clken = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        chk("level",      level,      m_level);
        chk("m_valid",    m_valid,    (m_level > 0));
        chk("rx_clken",   rx_clken,   e_clken);
        chk("rx_rdy_clr", rx_rdy_clr, e_clr);
        chk("overrun",    overrun,    e_ov);
        chk("ovr_cnt",    ovr_cnt,    e_oc);
        chk("frame_end",  frame_end,  e_fe);
        if (frame_end) fe_seen++;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_empty_sb: got m_data %0h expected no pop", m_data);
            end else begin
                e = exp_q.pop_front();
                chk("m_data", m_data, e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rnd_mode = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            m_ready = ($urandom_range(0, 1) == 1);
            ovr_clr = ($urandom_range(0, 31) == 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_clr = 0, input bit with_pop = 0);
        rx_data = b;
        rx_rdy  = 1'b1;
        if (with_clr) ovr_clr = 1'b1;
        if (with_pop) m_ready = 1'b1;
        step();
        if (with_clr) ovr_clr = 1'b0;
        if (with_pop) m_ready = 1'b0;
        step();
        rx_rdy = 1'b0;
        step();
    endtask

    task automatic drain();
        m_ready = 1'b1;
        repeat (DEPTH + 2) step();
        m_ready = 1'b0;
        step();
        chk("drain_level", level, 0);
        chk("drain_sb_empty", exp_q.size(), 0);
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr_flag", overrun, 0);
        chk("ovr_clr_cnt", ovr_cnt, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fe_base;
        repeat (3) step();
        chk("reset_level", level, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_valid", m_valid, 0);
        rstn = 1'b1;
        step();

        // baud generator, div=3
        div = 16'd3;
        en  = 1'b1;
        repeat (3) step();
        chk("clken_before_first", rx_clken, 0);
        step();
        chk("clken_first", rx_clken, 1);
        en = 1'b0;
        step();
        chk("clken_off", rx_clken, 0);
        en = 1'b1;
        repeat (20) step();
        en = 1'b0;
        div = 16'd0;
        step();
        en = 1'b1;
        repeat (5) step();
        chk("clken_div0", rx_clken, 1);

        // single byte
        rx_data = 8'hA5;
        rx_rdy  = 1'b1;
        step();
        chk("single_clr", rx_rdy_clr, 1);
        chk("single_valid", m_valid, 1);
        chk("single_data", m_data, 8'hA5);
        chk("single_level", level, 1);
        step();
        rx_rdy = 1'b0;
        chk("single_clr_end", rx_rdy_clr, 0);
        step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("single_pop_level", level, 0);
        chk("single_pop_valid", m_valid, 0);

        // overrun with 6 bytes into a 4-deep FIFO
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        chk("ovr6_flag", overrun, 1);
        chk("ovr6_cnt", ovr_cnt, 2);
        chk("ovr6_level", level, 4);
        drain();
        clear_ovr();

        // full FIFO, byte arrives in the same cycle as a pop
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        send_byte(8'h55, 0, 1);
        chk("fullpop_level", level, 4);
        chk("fullpop_no_drop", overrun, 0);
        drain();

        // counter saturation, then clear coinciding with a drop
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
        for (int i = 0; i < 257; i++) send_byte(8'($urandom));
        chk("sat_cnt", ovr_cnt, 255);
        send_byte(8'h77, 1, 0);
        chk("clr_drop_flag", overrun, 1);
        chk("clr_drop_cnt", ovr_cnt, 1);
        drain();
        clear_ovr();

`ifdef UART_RX_CTRL_IDLE_EN
        // idle end-of-frame with clken every cycle
        div = 16'd0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
        fe_base = fe_seen;
        repeat (IDLE + 20) step();
        chk("frame_end_once", fe_seen - fe_base, 1);
        repeat (IDLE + 40) step();
        chk("frame_end_no_repeat", fe_seen - fe_base, 1);
        m_ready = 1'b0;
`else
        fe_base = fe_seen;
        chk("frame_end_absent", fe_seen - fe_base, 0);
`endif

        // reset asserted mid-handshake with overrun set and data buffered
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
        rx_data = 8'h99;
        rx_rdy  = 1'b1;
        step();
        #2;
        rstn   = 1'b0;
        rx_rdy = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_clr", rx_rdy_clr, 0);
        chk("rst_clken", rx_clken, 0);
        repeat (2) step();
        rstn = 1'b1;
        step();

        // randomized traffic
        rnd_mode = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                en  = 1'b0;
                div = 16'($urandom_range(0, 5));
                step();
            end
            en = ($urandom_range(0, 9) != 0);
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 4)) step();
        end
        rnd_mode = 0;
        ovr_clr  = 1'b0;
        drain();

        // lowering div below the running count: count wraps through 0xFFFF
        en  = 1'b0;
        div = 16'd20;
        step();
        en = 1'b1;
        repeat (15) step();
        div = 16'd3;
        repeat (65536 + 20) step();
        en = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
